// File: rtl/xcorr_peak_scanner_pkg.sv
// Shared types, sizes and helpers for the multi-channel xcorr lag peak scanner.
// Holds the scan FSM encoding, lag/index widths and the saturating magnitude function.
package xcorr_peak_scanner_pkg;

  localparam int unsigned NUM_BITS_XCORRS = 34;
  localparam int unsigned MAX_LAGS        = 17;
  localparam int unsigned NUM_LAGS        = 2 * MAX_LAGS + 1;
  localparam int unsigned LAG_W           = $clog2(MAX_LAGS + 1) + 1;
  localparam int unsigned LAG_IDX_W       = $clog2(NUM_LAGS);

  typedef enum logic [1:0] {IDLE, SCAN, DONE} scan_state_t;

  typedef logic signed [NUM_BITS_XCORRS-1:0] xcorr_t;
  typedef xcorr_t [NUM_LAGS-1:0]             lag_vec_t;
  typedef logic signed [LAG_W-1:0]           lag_t;
  typedef logic [LAG_IDX_W-1:0]              lag_idx_t;

  localparam xcorr_t XCORR_MAX = {1'b0, {(NUM_BITS_XCORRS-1){1'b1}}};

  // |x| computed one bit wider; only the most-negative input overflows and saturates.
  function automatic xcorr_t abs_sat(input xcorr_t x);
    logic signed [NUM_BITS_XCORRS:0] mag;
    mag = x[NUM_BITS_XCORRS-1] ? -{x[NUM_BITS_XCORRS-1], x} : {x[NUM_BITS_XCORRS-1], x};
    if (mag[NUM_BITS_XCORRS-1]) return XCORR_MAX;
    return xcorr_t'(mag[NUM_BITS_XCORRS-1:0]);
  endfunction

endpackage

// File: rtl/xcorr_peak_scanner_if.sv
// Snapshot-in / result-out bus of the xcorr peak scanner.
//   in_valid/in_ready   : snapshot handshake (data_in, threshold)
//   out_valid/out_ready : result handshake (lag_out, peak_out, peak_found)
// master = producer/consumer side, slave = scanner side.
interface xcorr_peak_scanner_if
  import xcorr_peak_scanner_pkg::*;
#(
  parameter int unsigned NUM_CHANNELS = 3
);
  logic                          in_valid;
  logic                          in_ready;
  lag_vec_t [NUM_CHANNELS-1:0]   data_in;
  xcorr_t                        threshold;
  logic                          out_valid;
  logic                          out_ready;
  lag_t [NUM_CHANNELS-1:0]       lag_out;
  xcorr_t [NUM_CHANNELS-1:0]     peak_out;
  logic [NUM_CHANNELS-1:0]       peak_found;

  modport master (
    output in_valid, data_in, threshold, out_ready,
    input  in_ready, out_valid, lag_out, peak_out, peak_found
  );

  modport slave (
    input  in_valid, data_in, threshold, out_ready,
    output in_ready, out_valid, lag_out, peak_out, peak_found
  );
endinterface

// File: rtl/xcorr_peak_scanner_tracker.sv
// Per-channel running-max tracker.
//   scan_en/first : update enable; first forces an unconditional load (no zero seed)
//   idx/sample    : current lag index and its xcorr value
//   threshold     : registered snapshot threshold
//   finish        : latch lag/peak/found from the final running max
module xcorr_peak_scanner_tracker
  import xcorr_peak_scanner_pkg::*;
#(
  parameter bit ABS_MODE = 1'b0
) (
  input  logic     clk,
  input  logic     rst,
  input  logic     scan_en,
  input  logic     first,
  input  lag_idx_t idx,
  input  xcorr_t   sample,
  input  xcorr_t   threshold,
  input  logic     finish,
  output lag_t     lag,
  output xcorr_t   peak,
  output logic     found
);

  xcorr_t   cand_c;
  logic     hit_c;
  xcorr_t   max_q;
  lag_idx_t idx_q;

  assign cand_c = ABS_MODE ? abs_sat(sample) : sample;
  assign hit_c  = max_q > threshold;

  // Strict compare keeps the lowest index on ties.
  always_ff @(posedge clk) begin
    if (rst) begin
      max_q <= '0;
      idx_q <= '0;
      lag   <= '0;
      peak  <= '0;
      found <= 1'b0;
    end else begin
      if (scan_en && (first || cand_c > max_q)) begin
        max_q <= cand_c;
        idx_q <= idx;
      end
      if (finish) begin
        peak  <= max_q;
        found <= hit_c;
        lag   <= hit_c ? lag_t'(int'(idx_q) - int'(MAX_LAGS)) : '0;
      end
    end
  end

endmodule

// File: rtl/xcorr_peak_scanner.sv
// Multi-channel xcorr lag peak scanner: accepts one snapshot of NUM_LAGS values per channel,
// scans one lag per cycle across all channels, and returns signed lag, peak and found flag.
//   clk, rst : clock, synchronous active-high reset
//   bus      : slave side of xcorr_peak_scanner_if (snapshot in, results out)
module xcorr_peak_scanner
  import xcorr_peak_scanner_pkg::*;
#(
  parameter int unsigned NUM_CHANNELS = 3,
  parameter bit          ABS_MODE     = 1'b0
) (
  input  logic                   clk,
  input  logic                   rst,
  xcorr_peak_scanner_if.slave    bus
);

  scan_state_t                 state, state_next;
  lag_idx_t                    cnt;
  lag_vec_t [NUM_CHANNELS-1:0] snap;
  xcorr_t                      thr_q;
  logic                        in_ready_q;
  logic                        out_valid_q;
  logic                        fin_q;
  logic                        accept_c, scan_en_c, last_c;

  // Next-state and per-cycle strobes.
  always_comb begin
    state_next = state;
    accept_c   = 1'b0;
    scan_en_c  = 1'b0;
    last_c     = 1'b0;
    unique case (state)
      IDLE: begin
        if (bus.in_valid && in_ready_q) begin
          accept_c   = 1'b1;
          state_next = SCAN;
        end
      end
      SCAN: begin
        scan_en_c = 1'b1;
        if (cnt == lag_idx_t'(NUM_LAGS - 1)) begin
          last_c     = 1'b1;
          state_next = DONE;
        end
      end
      DONE: begin
        if (out_valid_q && bus.out_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // State, lag counter, snapshot capture and handshake flags.
  // fin_q delays result registration one cycle so it sees the last lag's update.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      cnt         <= '0;
      snap        <= '0;
      thr_q       <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      fin_q       <= 1'b0;
    end else begin
      state      <= state_next;
      in_ready_q <= (state_next == IDLE);
      fin_q      <= last_c;
      if (accept_c) begin
        snap  <= bus.data_in;
        thr_q <= bus.threshold;
        cnt   <= '0;
      end else if (scan_en_c) begin
        cnt <= last_c ? '0 : cnt + lag_idx_t'(1);
      end
      if (fin_q) begin
        out_valid_q <= 1'b1;
      end else if (state == DONE && bus.out_ready) begin
        out_valid_q <= 1'b0;
      end
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;

  lag_t [NUM_CHANNELS-1:0]   lag_w;
  xcorr_t [NUM_CHANNELS-1:0] peak_w;
  logic [NUM_CHANNELS-1:0]   found_w;

  for (genvar c = 0; c < NUM_CHANNELS; c++) begin : g_ch
    xcorr_peak_scanner_tracker #(.ABS_MODE(ABS_MODE)) u_trk (
      .clk       (clk),
      .rst       (rst),
      .scan_en   (scan_en_c),
      .first     (cnt == '0),
      .idx       (cnt),
      .sample    (snap[c][cnt]),
      .threshold (thr_q),
      .finish    (fin_q),
      .lag       (lag_w[c]),
      .peak      (peak_w[c]),
      .found     (found_w[c])
    );
  end

  assign bus.lag_out    = lag_w;
  assign bus.peak_out   = peak_w;
  assign bus.peak_found = found_w;

endmodule
